// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: pulses PLL RESET, qualifies a synchronized lock, then
// releases per-domain active-low resets one by one, with retry and fault latching.
module pll_reset_sequencer #(
    parameter int NUM_CH             = 2,
    parameter int PLL_RST_CYC        = 16,
    parameter int LOCK_STABLE_CYC    = 1024,
    parameter int RELOCK_TIMEOUT_CYC = 500000,
    parameter int STAGGER_CYC        = 64,
    parameter int MAX_RETRY          = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              force_relock,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              ready,
    output logic              fault,
    output logic [3:0]        retry_count,
    output logic [7:0]        lock_loss_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    localparam int REL_CYC = (NUM_CH > 1) ? (NUM_CH - 1) * STAGGER_CYC : 1;
    localparam int MAX_AB  = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CD  = (RELOCK_TIMEOUT_CYC > REL_CYC) ? RELOCK_TIMEOUT_CYC : REL_CYC;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RELOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(REL_CYC - 1);
    // The WAIT_LOCK cycle that saw lock_s already counts as the first stable cycle.
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE_CYC >= 2) ? LOCK_STABLE_CYC - 2 : 0);

    state_e              state_q, state_d, rel_st;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          sync_q, sync_d;
    logic [3:0]          retry_q, retry_d;
    logic [7:0]          lls_q, lls_d;
    logic                pll_reset_q, pll_reset_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
    logic                lock_s;

    assign lock_s = sync_q[1];
    assign rel_st = (NUM_CH == 1) ? S_RUN : S_RELEASE;

    always_comb begin
        sync_d  = {sync_q[0], pll_lock};
        state_d = state_q;
        retry_d = retry_q;
        lls_d   = lls_q;
        case (state_q)
            S_PLL_RST: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = (LOCK_STABLE_CYC <= 1) ? rel_st : S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    if (MAX_RETRY != 0 && retry_q == 4'(MAX_RETRY)) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_PLL_RST;
                        retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = rel_st;
            end
            S_RELEASE, S_RUN: begin
                if (!lock_s) begin
                    state_d = S_PLL_RST;
                    retry_d = 4'd0;
                    lls_d   = (lls_q == 8'hff) ? lls_q : lls_q + 8'd1;
                end else if (state_q == S_RELEASE && cnt_q == REL_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_PLL_RST;
        endcase
        // A relock request overrides any lock-loss or timeout decision above.
        if (force_relock && state_q != S_PLL_RST) begin
            state_d = S_PLL_RST;
            retry_d = 4'd0;
            lls_d   = lls_q;
        end

        if (state_d != state_q || state_q == S_RUN || state_q == S_FAULT) cnt_d = '0;
        else                                                              cnt_d = cnt_q + CW'(1);

        // Outputs are derived from the next state so they register alongside it.
        pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
        fault_d     = (state_d == S_FAULT);
        ready_d     = (state_d == S_RUN);
        for (int k = 0; k < NUM_CH; k++) begin
            rst_n_d[k] = (state_d == S_RUN) ||
                         (state_d == S_RELEASE && cnt_d >= CW'(k * STAGGER_CYC));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            sync_q      <= 2'b00;
            retry_q     <= 4'd0;
            lls_q       <= 8'd0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            rst_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            retry_q     <= retry_d;
            lls_q       <= lls_d;
            pll_reset_q <= pll_reset_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            rst_n_q     <= rst_n_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign rst_n_out     = rst_n_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_count   = retry_q;
    assign lock_loss_cnt = lls_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters; all
// expected cycle positions are hand-derived from the sequencing rules.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic [2:0] rst_n_out;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int vec;
    int err;

    pll_reset_sequencer #(
        .NUM_CH(3), .PLL_RST_CYC(4), .LOCK_STABLE_CYC(8),
        .RELOCK_TIMEOUT_CYC(20), .STAGGER_CYC(3), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .force_relock(force_relock),
        .pll_reset(pll_reset), .rst_n_out(rst_n_out), .ready(ready), .fault(fault),
        .retry_count(retry_count), .lock_loss_cnt(lock_loss_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        resetn = 1'b0; pll_lock = 1'b0; force_relock = 1'b0;
        repeat (3) @(negedge clk);
        vec++; if (state !== 3'd0) begin err++; $display("FAIL reset_state got %0d exp 0", state); end
        vec++; if (pll_reset !== 1'b1) begin err++; $display("FAIL reset_pll_reset got %b exp 1", pll_reset); end
        vec++; if (rst_n_out !== 3'b000) begin err++; $display("FAIL reset_rst_n got %b exp 000", rst_n_out); end
        vec++; if (ready !== 1'b0) begin err++; $display("FAIL reset_ready got %b exp 0", ready); end
        vec++; if (fault !== 1'b0) begin err++; $display("FAIL reset_fault got %b exp 0", fault); end
        vec++; if (retry_count !== 4'd0) begin err++; $display("FAIL reset_retry got %0d exp 0", retry_count); end
        vec++; if (lock_loss_cnt !== 8'd0) begin err++; $display("FAIL reset_lls got %0d exp 0", lock_loss_cnt); end
    endtask

    task automatic test_clean_start;
        int hi = 0, r0 = -1, r1 = -1, r2 = -1, rr = -1;
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (pll_reset) hi++;
            if (r0 < 0 && rst_n_out[0]) r0 = i;
            if (r1 < 0 && rst_n_out[1]) r1 = i;
            if (r2 < 0 && rst_n_out[2]) r2 = i;
            if (rr < 0 && ready) rr = i;
            if (i == 5) pll_lock = 1'b1;
            @(negedge clk);
        end
        vec++; if (hi != 4) begin err++; $display("FAIL clean_pll_reset_len got %0d exp 4", hi); end
        vec++; if (r0 != 15) begin err++; $display("FAIL clean_ch0_rise got %0d exp 15", r0); end
        vec++; if (r1 != 18) begin err++; $display("FAIL clean_ch1_rise got %0d exp 18", r1); end
        vec++; if (r2 != 21) begin err++; $display("FAIL clean_ch2_rise got %0d exp 21", r2); end
        vec++; if (rr != 21) begin err++; $display("FAIL clean_ready_rise got %0d exp 21", rr); end
        vec++; if (state !== 3'd4) begin err++; $display("FAIL clean_state got %0d exp 4", state); end
        vec++; if (retry_count !== 4'd0) begin err++; $display("FAIL clean_retry got %0d exp 0", retry_count); end
    endtask

    task automatic test_lock_glitch;
        int t = 0, r0 = -1, r1 = -1, r2 = -1;
        force_relock = 1'b1; pll_lock = 1'b0;
        @(negedge clk);
        force_relock = 1'b0;
        while (state !== 3'd1 && t < 20) begin @(negedge clk); t++; end
        vec++; if (t >= 20) begin err++; $display("FAIL glitch_wait_lock timeout state %0d exp 1", state); end
        for (int i = 0; i < 30; i++) begin
            if (r0 < 0 && rst_n_out[0]) r0 = i;
            if (r1 < 0 && rst_n_out[1]) r1 = i;
            if (r2 < 0 && rst_n_out[2]) r2 = i;
            if (i == 7) begin
                vec++; if (state !== 3'd2) begin err++; $display("FAIL glitch_state_n7 got %0d exp 2", state); end
            end
            if (i == 8) begin
                vec++; if (state !== 3'd1) begin err++; $display("FAIL glitch_state_n8 got %0d exp 1", state); end
            end
            if (i == 0) pll_lock = 1'b1;
            if (i == 5) pll_lock = 1'b0;
            if (i == 6) pll_lock = 1'b1;
            @(negedge clk);
        end
        vec++; if (r0 != 16) begin err++; $display("FAIL glitch_ch0_rise got %0d exp 16", r0); end
        vec++; if (r1 != 19) begin err++; $display("FAIL glitch_ch1_rise got %0d exp 19", r1); end
        vec++; if (r2 != 22) begin err++; $display("FAIL glitch_ch2_rise got %0d exp 22", r2); end
        vec++; if (retry_count !== 4'd0) begin err++; $display("FAIL glitch_retry got %0d exp 0", retry_count); end
    endtask

    task automatic test_no_lock;
        int hi = 0, nr = 0;
        int rise[4];
        logic prev;
        rise = '{-1, -1, -1, -1};
        prev = pll_reset;
        for (int i = 0; i < 80; i++) begin
            if (i > 0 && pll_reset && !prev && nr < 4) begin rise[nr] = i; nr++; end
            if (i >= 1 && i <= 72 && pll_reset) hi++;
            prev = pll_reset;
            if (i == 25) begin
                vec++; if (retry_count !== 4'd1) begin err++; $display("FAIL nolock_retry_1 got %0d exp 1", retry_count); end
            end
            if (i == 72) begin
                vec++; if (fault !== 1'b0) begin err++; $display("FAIL nolock_fault_early got %b exp 0", fault); end
            end
            if (i == 73) begin
                vec++; if (fault !== 1'b1) begin err++; $display("FAIL nolock_fault got %b exp 1", fault); end
            end
            if (i == 0) begin force_relock = 1'b1; pll_lock = 1'b0; end
            if (i == 1) force_relock = 1'b0;
            @(negedge clk);
        end
        vec++; if (rise[0] != 1)  begin err++; $display("FAIL nolock_rise0 got %0d exp 1", rise[0]); end
        vec++; if (rise[1] != 25) begin err++; $display("FAIL nolock_rise1 got %0d exp 25", rise[1]); end
        vec++; if (rise[2] != 49) begin err++; $display("FAIL nolock_rise2 got %0d exp 49", rise[2]); end
        vec++; if (rise[3] != 73) begin err++; $display("FAIL nolock_fault_rise got %0d exp 73", rise[3]); end
        vec++; if (hi != 12) begin err++; $display("FAIL nolock_pulse_cycles got %0d exp 12", hi); end
        vec++; if (state !== 3'd5) begin err++; $display("FAIL nolock_state got %0d exp 5", state); end
        vec++; if (retry_count !== 4'd2) begin err++; $display("FAIL nolock_retry got %0d exp 2", retry_count); end
        vec++; if (pll_reset !== 1'b1) begin err++; $display("FAIL nolock_pll_reset got %b exp 1", pll_reset); end
    endtask

    task automatic test_fault_recovery;
        int r0 = -1, rr = -1;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) begin
                vec++; if (fault !== 1'b0) begin err++; $display("FAIL recov_fault got %b exp 0", fault); end
                vec++; if (retry_count !== 4'd0) begin err++; $display("FAIL recov_retry got %0d exp 0", retry_count); end
                vec++; if (state !== 3'd0) begin err++; $display("FAIL recov_state got %0d exp 0", state); end
                vec++; if (pll_reset !== 1'b1) begin err++; $display("FAIL recov_pll_reset got %b exp 1", pll_reset); end
            end
            if (r0 < 0 && rst_n_out[0]) r0 = i;
            if (rr < 0 && ready) rr = i;
            if (i == 0) force_relock = 1'b1;
            if (i == 1) begin force_relock = 1'b0; pll_lock = 1'b1; end
            @(negedge clk);
        end
        vec++; if (r0 != 13) begin err++; $display("FAIL recov_ch0_rise got %0d exp 13", r0); end
        vec++; if (rr != 19) begin err++; $display("FAIL recov_ready_rise got %0d exp 19", rr); end
        vec++; if (lock_loss_cnt !== 8'd0) begin err++; $display("FAIL recov_lls got %0d exp 0", lock_loss_cnt); end
    endtask

    task automatic test_lock_loss;
        int r0 = -1, r1 = -1, r2 = -1, t;
        bit to = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) begin
                vec++; if (ready !== 1'b1) begin err++; $display("FAIL loss_ready_early got %b exp 1", ready); end
            end
            if (i == 3) begin
                vec++; if (rst_n_out !== 3'b000) begin err++; $display("FAIL loss_rst_n got %b exp 000", rst_n_out); end
                vec++; if (ready !== 1'b0) begin err++; $display("FAIL loss_ready got %b exp 0", ready); end
                vec++; if (lock_loss_cnt !== 8'd1) begin err++; $display("FAIL loss_lls got %0d exp 1", lock_loss_cnt); end
                vec++; if (state !== 3'd0) begin err++; $display("FAIL loss_state got %0d exp 0", state); end
            end
            if (i > 3 && r0 < 0 && rst_n_out[0]) r0 = i;
            if (i > 3 && r1 < 0 && rst_n_out[1]) r1 = i;
            if (i > 3 && r2 < 0 && rst_n_out[2]) r2 = i;
            if (i == 0) pll_lock = 1'b0;
            if (i == 3) pll_lock = 1'b1;
            @(negedge clk);
        end
        vec++; if (r0 != 15) begin err++; $display("FAIL loss_ch0_rise got %0d exp 15", r0); end
        vec++; if (r1 != 18) begin err++; $display("FAIL loss_ch1_rise got %0d exp 18", r1); end
        vec++; if (r2 != 21) begin err++; $display("FAIL loss_ch2_rise got %0d exp 21", r2); end
        // 254 more drops bring the count to 255; one further drop must not wrap it.
        for (int n = 0; n < 255 && !to; n++) begin
            pll_lock = 1'b0;
            @(negedge clk);
            pll_lock = 1'b1;
            t = 0;
            while (state !== 3'd0 && t < 10) begin @(negedge clk); t++; end
            if (t >= 10) to = 1'b1;
            t = 0;
            while (ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
            if (t >= 40) to = 1'b1;
            if (n == 253) begin
                vec++; if (lock_loss_cnt !== 8'd255) begin err++; $display("FAIL sat_lls_255 got %0d exp 255", lock_loss_cnt); end
            end
        end
        vec++; if (to) begin err++; $display("FAIL sat_loop timeout state %0d ready %b", state, ready); end
        vec++; if (lock_loss_cnt !== 8'd255) begin err++; $display("FAIL sat_lls_hold got %0d exp 255", lock_loss_cnt); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 74; i++) begin
            if (i == 72) begin
                vec++; if (state !== 3'd1) begin err++; $display("FAIL simul_pre_state got %0d exp 1", state); end
                vec++; if (retry_count !== 4'd2) begin err++; $display("FAIL simul_pre_retry got %0d exp 2", retry_count); end
            end
            if (i == 73) begin
                vec++; if (state !== 3'd0) begin err++; $display("FAIL simul_state got %0d exp 0", state); end
                vec++; if (fault !== 1'b0) begin err++; $display("FAIL simul_fault got %b exp 0", fault); end
                vec++; if (retry_count !== 4'd0) begin err++; $display("FAIL simul_retry got %0d exp 0", retry_count); end
                vec++; if (pll_reset !== 1'b1) begin err++; $display("FAIL simul_pll_reset got %b exp 1", pll_reset); end
            end
            if (i == 0) begin force_relock = 1'b1; pll_lock = 1'b0; end
            if (i == 1) force_relock = 1'b0;
            if (i == 72) force_relock = 1'b1;
            if (i == 73) force_relock = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_release;
        int t = 0;
        pll_lock = 1'b1;
        while (state !== 3'd3 && t < 40) begin @(negedge clk); t++; end
        vec++; if (t >= 40) begin err++; $display("FAIL midrel_wait timeout state %0d exp 3", state); end
        vec++; if (rst_n_out[0] !== 1'b1) begin err++; $display("FAIL midrel_ch0 got %b exp 1", rst_n_out[0]); end
        #2 resetn = 1'b0;
        #1;
        vec++; if (state !== 3'd0) begin err++; $display("FAIL midrel_state got %0d exp 0", state); end
        vec++; if (pll_reset !== 1'b1) begin err++; $display("FAIL midrel_pll_reset got %b exp 1", pll_reset); end
        vec++; if (rst_n_out !== 3'b000) begin err++; $display("FAIL midrel_rst_n got %b exp 000", rst_n_out); end
        vec++; if (ready !== 1'b0 || fault !== 1'b0) begin err++; $display("FAIL midrel_ready_fault got %b%b exp 00", ready, fault); end
        vec++; if (lock_loss_cnt !== 8'd0) begin err++; $display("FAIL midrel_lls got %0d exp 0", lock_loss_cnt); end
        @(negedge clk);
        resetn = 1'b1;
        t = 0;
        while (ready !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        vec++; if (t >= 60) begin err++; $display("FAIL midrel_restart timeout ready %b", ready); end
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset();
        test_clean_start();
        test_lock_glitch();
        test_no_lock();
        test_fault_recovery();
        test_lock_loss();
        test_simultaneous();
        test_reset_mid_release();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Lock supervisor and reset sequencer for the PLLA-based clock generators (HDMI pixel/serial and later clock domains).
- Runs on the free-running PLL input reference clock.
- Drives the PLL RESET pin, filters the LOCK output, and releases per-domain active-low resets in a staggered order.
- Detects lock loss, retries with a timeout, and latches a fault after a configurable number of failed attempts.

Parameters:
- NUM_CH, 2, number of downstream reset channels (1..8).
- PLL_RST_CYC, 16, cycles pll_reset is held high per attempt.
- LOCK_STABLE_CYC, 1024, consecutive synchronized-lock cycles required before release.
- RELOCK_TIMEOUT_CYC, 500000, cycles to wait for lock before retrying (10 ms at 50 MHz).
- STAGGER_CYC, 64, cycles between release of consecutive channels.
- MAX_RETRY, 3, retries before FAULT; 0 = retry forever.

Ports:
- clk  in  1  reference clock, same source as the PLL clkin
- resetn  in  1  asynchronous active-low reset
- pll_lock  in  1  raw PLL lock (asynchronous to clk)
- force_relock  in  1  single-cycle request to restart the PLL
- pll_reset  out  1  to PLL RESET, active high
- rst_n_out  out  NUM_CH  per-domain resets, active low; consumers resynchronize the deassertion
- ready  out  1  all channels released
- fault  out  1  retry limit exhausted
- retry_count  out  4  failed attempts since last clean start, saturating at 15
- lock_loss_cnt  out  8  lock drops seen in RUN, saturating at 255
- state  out  3  debug encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5

Behaviour:
- Reset values (resetn low): state=PLL_RST, pll_reset=1, rst_n_out=all 0, ready=0, fault=0, retry_count=0, lock_loss_cnt=0, counters=0. The synchronizer flops reset to 0.
- pll_lock passes through a 2-flop synchronizer, giving lock_s. All lock decisions use lock_s, so there are 2 cycles of latency.
- A single counter cnt is used, with width clog2(max of the cycle parameters)+1. cnt clears on every state transition.
- PLL_RST:
  - pll_reset=1 and all rst_n_out=0.
  - After PLL_RST_CYC cycles -> WAIT_LOCK.
  - force_relock is ignored in this state.
- WAIT_LOCK:
  - pll_reset=0.
  - lock_s=1 -> STABLE.
  - Otherwise cnt increments. At cnt==RELOCK_TIMEOUT_CYC-1:
    - if MAX_RETRY!=0 and retry_count==MAX_RETRY -> FAULT;
    - else retry_count++ and -> PLL_RST.
- STABLE:
  - lock_s=0 -> WAIT_LOCK. retry_count is unchanged and the timeout restarts.
  - LOCK_STABLE_CYC consecutive lock_s=1 cycles -> RELEASE.
- RELEASE:
  - rst_n_out[0] goes high on the first RELEASE cycle.
  - rst_n_out[k] goes high exactly k*STAGGER_CYC cycles after rst_n_out[0].
  - ready goes high in the same cycle as rst_n_out[NUM_CH-1], with the transition to RUN.
  - NUM_CH=1: rst_n_out[0] and ready rise together.
  - A lock_s drop is handled as in RUN.
- RUN:
  - Holds outputs.
  - lock_s=0 -> next cycle: all rst_n_out=0, ready=0, lock_loss_cnt++ (saturating), retry_count=0, -> PLL_RST.
- FAULT:
  - pll_reset=1, all rst_n_out=0, fault=1.
  - The only exits are force_relock or resetn.
- force_relock=1 in any state except PLL_RST:
  - Next cycle: state=PLL_RST, all rst_n_out=0, ready=0, fault=0, retry_count=0. lock_loss_cnt is unchanged.
  - It takes priority over a simultaneous lock loss or timeout in the same cycle.
- Reset assertion order: every rst_n_out bit drops in the same cycle. Only deassertion is staggered.
- Outputs are registered, with no combinational path from pll_lock or force_relock.
- resetn asserted mid-operation: all outputs take their reset values immediately (asynchronously). The sequence restarts from PLL_RST after release.

Test Plan (NUM_CH=3, PLL_RST_CYC=4, LOCK_STABLE_CYC=8, STAGGER_CYC=3, RELOCK_TIMEOUT_CYC=20, MAX_RETRY=2):
- Clean start: resetn rises, pll_lock high from cycle 6 -> pll_reset high for exactly 4 cycles. rst_n_out[0] rises 8 cycles after lock_s rises, [1] +3 cycles, [2] +6 cycles. ready rises with [2].
- Lock glitch in STABLE: lock low for 1 cycle after 5 stable cycles -> no channel released. The 8-cycle count restarts, and retry_count stays 0.
- Lock never rises -> pll_reset pulses 3 times, 4 cycles each, 20 WAIT_LOCK cycles apart. After the third timeout: fault=1, retry_count=2, state=5, pll_reset held 1.
- Fault recovery: force_relock pulse in FAULT, then lock -> fault=0 next cycle, retry_count=0, normal release sequence to ready=1.
- Lock loss in RUN: drop pll_lock -> 3 cycles later all rst_n_out=0, ready=0, lock_loss_cnt=1, state=0. Relock leads to full staggered release again. 256 losses saturate the counter at 255.
- Simultaneous: force_relock in the same cycle as a WAIT_LOCK timeout with retry_count==2 -> PLL_RST, not FAULT, retry_count=0. resetn pulsed mid-RELEASE -> all outputs at reset values immediately.
